led_frame_ctrl: RTL
===================

LED_FRAME_CTRL -- requirements
Module: led_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, meaning visible pixels per frame (1..1024).
REQ-002 SHALL have parameter AW, default 3, meaning pixel address width; ceil(log2(NUM_LEDS)) <= AW <= 10.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  host pixel write strobe.
REQ-006 SHALL have port wr_addr  input  AW  host pixel index.
REQ-007 SHALL have port wr_data  input  24  host pixel value, passed to tape unmodified in bit order.
REQ-008 SHALL have port commit  input  1  host request to display back buffer.
REQ-009 SHALL have port busy  output  1  commit pending; host writes and commits refused.
REQ-010 SHALL have port wr_err  output  1  one-cycle pulse: write or commit refused.
REQ-011 SHALL have port req  input  1  one-cycle pixel request from tape driver.
REQ-012 SHALL have port num  input  16  pixel index from tape driver, valid while req=1.
REQ-013 SHALL have port sync  input  1  tape driver reset-gap flag (high while latching).
REQ-014 SHALL have port RGB  output  24  pixel value to tape driver.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse on each sync rising edge.

Function
REQ-016 SHALL hold two NUM_LEDS x 24 pixel banks: front (displayed) and back (host-written); bank select bit sel.
REQ-017 On req=1 with num<NUM_LEDS, RGB SHALL equal front[num] from the next cycle and hold until the next req.
REQ-018 On req=1 with num>=NUM_LEDS, RGB SHALL become 24'h000000 on the next cycle.
REQ-019 Latency req->RGB SHALL be exactly one clock; RGB SHALL NOT change on cycles without req.
REQ-020 wr_en=1 with busy=0 and wr_addr<NUM_LEDS SHALL write wr_data to back[wr_addr] that cycle.
REQ-021 wr_en=1 with wr_addr>=NUM_LEDS SHALL be dropped and pulse wr_err.
REQ-022 State machine IDLE->PENDING on commit=1 in IDLE; busy=1 exactly in PENDING.
REQ-023 PENDING->IDLE on sync rising edge (sync=1, previous cycle sync=0); same edge toggles sel.
REQ-024 commit=1 or wr_en=1 in PENDING SHALL be ignored and pulse wr_err the next cycle.
REQ-025 commit and sync rising edge in same IDLE cycle: enter PENDING; swap waits for next sync rising edge.
REQ-026 req on the same cycle as swap SHALL read the pre-swap front bank.
REQ-027 After swap the new back bank holds the frame shown before swap; no copy occurs.
REQ-028 frame_done SHALL pulse one cycle after every sync rising edge, regardless of state.

Reset
REQ-029 rst=1 SHALL force IDLE, sel=0, busy=0, wr_err=0, frame_done=0, RGB=0, sync history=1.
REQ-030 rst SHALL NOT clear bank contents; a pending commit at reset SHALL be discarded.
REQ-031 Sync history reset to 1 SHALL prevent a false edge if sync is high when rst releases.

Configuration
REQ-032 Macro LED_FRAME_BRIGHTNESS_EN, when defined, SHALL add port bright input 8 global brightness.
REQ-033 With macro, each 8-bit channel of RGB SHALL be (c*(bright+1))>>8, inside the same one-cycle latency.
REQ-034 Without macro, port bright SHALL be absent and RGB SHALL equal the stored pixel exactly.

Verification
REQ-035 Write back[0..7]=24'h000001..24'h000008, commit, sync 0->1 -> busy 1 then 0, frame_done pulse, req num=3 -> RGB=24'h000004 one cycle later.
REQ-036 req with num=8 (NUM_LEDS=8) -> RGB=24'h000000; req with num=0 -> front[0].
REQ-037 commit then wr_en addr 2 data 24'hFFFFFF before sync -> wr_err pulse, back[2] unchanged after swap.
REQ-038 commit with sync rising same cycle -> no swap; swap on following sync rising edge.
REQ-039 rst asserted while PENDING with sync held high -> busy=0, RGB=0, no frame_done or swap on rst release.
REQ-040 LED_FRAME_BRIGHTNESS_EN defined, pixel 24'hFF8040, bright=127 -> RGB=24'h7F4020; bright=255 -> 24'hFF8040.

Source files
------------

// File: rtl/led_frame_ctrl.sv
// led_frame_ctrl: double-buffered pixel store that serves a LED tape driver.
// Optional LED_FRAME_BRIGHTNESS_EN adds a global brightness input per channel.
module led_frame_ctrl #(
    parameter int NUM_LEDS = 8,
    parameter int AW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          commit,
    output logic          busy,
    output logic          wr_err,
    input  logic          req,
    input  logic [15:0]   num,
    input  logic          sync,
`ifdef LED_FRAME_BRIGHTNESS_EN
    input  logic [7:0]    bright,
`endif
    output logic [23:0]   RGB,
    output logic          frame_done
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    localparam logic [AW:0] WR_LIMIT = (AW + 1)'(NUM_LEDS);
    localparam logic [15:0] RD_LIMIT = 16'(NUM_LEDS);

    state_t      state;
    state_t      state_nxt;
    logic        sel;
    logic        sync_q;
    logic        sync_rise;
    logic        swap;
    logic        wr_in_range;
    logic        rd_in_range;
    logic        wr_ok;
    logic        refused;
    logic [23:0] pix;
    logic [23:0] shaded;

    logic [23:0] mem [2][NUM_LEDS];

    assign sync_rise   = sync & ~sync_q;
    assign wr_in_range = {1'b0, wr_addr} < WR_LIMIT;
    assign rd_in_range = num < RD_LIMIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A commit arriving with a sync edge only arms; the swap waits for the next edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (commit) state_nxt = PENDING;
            PENDING: if (sync_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == PENDING);
        swap = (state == PENDING) && sync_rise;
    end

    assign wr_ok   = wr_en && !busy && wr_in_range;
    assign refused = (wr_en && (busy || !wr_in_range)) || (commit && busy);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel        <= 1'b0;
            sync_q     <= 1'b1;
            frame_done <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            if (swap) sel <= ~sel;
            sync_q     <= sync;
            frame_done <= sync_rise;
            wr_err     <= refused;
        end
    end

    // Banks are never cleared; the back bank is always the one sel does not point at.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[~sel][wr_addr] <= wr_data;
        end
    end

    assign pix = mem[sel][num[AW-1:0]];

`ifdef LED_FRAME_BRIGHTNESS_EN
    function automatic logic [7:0] scale(
        input logic [7:0] c,
        input logic [7:0] b
    );
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction

    assign shaded = {
        scale(pix[23:16], bright),
        scale(pix[15:8],  bright),
        scale(pix[7:0],   bright)
    };
`else
    assign shaded = pix;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            RGB <= 24'h000000;
        end else if (req) begin
            RGB <= rd_in_range ? shaded : 24'h000000;
        end
    end

endmodule
